match_result_streamer: RTL

MATCH_RESULT_STREAMER -- requirements
Module: match_result_streamer

---
 rtl/match_result_streamer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/match_result_streamer.sv
// Unloads the four matched-entry banks as a 16-bit word stream. Each bank gets a header,
// then three words per entry; a trailer carries the grand total.
module match_result_streamer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [9:0]  match_cnt_0,
   input  logic [9:0]  match_cnt_1,
   input  logic [9:0]  match_cnt_2,
   input  logic [9:0]  match_cnt_3,
   output logic [8:0]  matched_addr,
   input  logic [46:0] matched_dout_0,
   input  logic [46:0] matched_dout_1,
   input  logic [46:0] matched_dout_2,
   input  logic [46:0] matched_dout_3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      StIdle, StBankHdr, StFetch, StLatch, StSend, StTrailer, StFin
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       bank_q, bank_d;
   logic [9:0]       entry_q, entry_d;
   logic [1:0]       word_q, word_d;
   logic [3:0][9:0]  cnt_q, cnt_d;
   logic [11:0]      total_q, total_d;
   logic [46:0]      hold_q, hold_d;
   logic [8:0]       addr_q, addr_d;

   logic [9:0]       cur_cnt;
   logic [46:0]      bank_dout;
   logic [9:0]       entry_nxt;

   function automatic logic [9:0] clamp(input logic [9:0] c);
      return (c > 10'd512) ? 10'd512 : c;
   endfunction

   assign cur_cnt      = cnt_q[bank_q];
   assign entry_nxt    = entry_q + 10'd1;
   assign matched_addr = addr_q;

   always_comb begin
      unique case (bank_q)
         2'd0:    bank_dout = matched_dout_0;
         2'd1:    bank_dout = matched_dout_1;
         2'd2:    bank_dout = matched_dout_2;
         default: bank_dout = matched_dout_3;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      entry_d   = entry_q;
      word_d    = word_q;
      cnt_d     = cnt_q;
      total_d   = total_q;
      hold_d    = hold_q;
      addr_d    = addr_q;
      out_valid = 1'b0;
      out_data  = 16'h0000;
      done      = 1'b0;
      busy      = (state_q != StIdle) && (state_q != StFin);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d[0] = clamp(match_cnt_0);
               cnt_d[1] = clamp(match_cnt_1);
               cnt_d[2] = clamp(match_cnt_2);
               cnt_d[3] = clamp(match_cnt_3);
               total_d  = {2'b00, cnt_d[0]} + {2'b00, cnt_d[1]} +
                          {2'b00, cnt_d[2]} + {2'b00, cnt_d[3]};
               bank_d   = 2'd0;
               state_d  = StBankHdr;
            end
         end
         StBankHdr: begin
            out_valid = 1'b1;
            out_data  = {4'hB, bank_q, cur_cnt};
            if (out_ready) begin
               if (cur_cnt != 10'd0) begin
                  entry_d = 10'd0;
                  addr_d  = 9'd0;
                  state_d = StFetch;
               end else if (bank_q == 2'd3) begin
                  state_d = StTrailer;
               end else begin
                  bank_d  = bank_q + 2'd1;
                  state_d = StBankHdr;
               end
            end
         end
         StFetch: state_d = StLatch;
         StLatch: begin
            // Read data for addr_q arrives one cycle after the FETCH cycle.
            hold_d  = bank_dout;
            word_d  = 2'd0;
            state_d = StSend;
         end
         StSend: begin
            out_valid = 1'b1;
            unique case (word_q)
               2'd0:    out_data = {1'b0, hold_q[46:32]};
               2'd1:    out_data = hold_q[31:16];
               default: out_data = hold_q[15:0];
            endcase
            if (out_ready) begin
               if (word_q != 2'd2) begin
                  word_d = word_q + 2'd1;
               end else if (entry_nxt < cur_cnt) begin
                  entry_d = entry_nxt;
                  addr_d  = entry_nxt[8:0];
                  state_d = StFetch;
               end else if (bank_q == 2'd3) begin
                  state_d = StTrailer;
               end else begin
                  bank_d  = bank_q + 2'd1;
                  state_d = StBankHdr;
               end
            end
         end
         StTrailer: begin
            out_valid = 1'b1;
            out_data  = {4'hE, total_q};
            if (out_ready) state_d = StFin;
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         bank_q  <= 2'd0;
         entry_q <= 10'd0;
         word_q  <= 2'd0;
         cnt_q   <= '0;
         total_q <= 12'd0;
         hold_q  <= 47'd0;
         addr_q  <= 9'd0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         entry_q <= entry_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         hold_q  <= hold_d;
         addr_q  <= addr_d;
      end
   end

endmodule
